// File: rtl/usr_input_pkg.sv
// Shared types and constants for the user key/switch debouncer.
package usr_input_pkg;

  localparam int unsigned NUM_KEYS = 3;
  localparam int unsigned NUM_SWS  = 3;

  // 20 ms and 1 s at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50_000_000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  // One counter width covers both the stability and the hold counters.
  function automatic int unsigned cnt_width(input int unsigned long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/usr_input_debounce_if.sv
// Raw key/switch inputs and debounced levels/events of the user input block.
interface usr_input_debounce_if;
  import usr_input_pkg::*;

  logic [NUM_KEYS-1:0] usr_key_i;
  logic [NUM_SWS-1:0]  usr_sw_i;
  logic [NUM_KEYS-1:0] key_level_o;
  logic [NUM_KEYS-1:0] key_press_o;
  logic [NUM_KEYS-1:0] key_release_o;
  logic [NUM_KEYS-1:0] key_long_o;
  logic [NUM_SWS-1:0]  sw_level_o;
  logic [NUM_SWS-1:0]  sw_change_o;

  modport slave (
    input  usr_key_i, usr_sw_i,
    output key_level_o, key_press_o, key_release_o, key_long_o,
           sw_level_o, sw_change_o
  );

  modport master (
    output usr_key_i, usr_sw_i,
    input  key_level_o, key_press_o, key_release_o, key_long_o,
           sw_level_o, sw_change_o
  );

endinterface

// File: rtl/usr_input_db_channel.sv
// One debounce channel: 2-flop synchronizer, optional inversion, 4-state
// stability FSM with registered level and rise/fall pulses.
module usr_input_db_channel
  import usr_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             sample_c;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_d, fall_d;

  // Synchronizer resets to the idle pin level (released key / switch off).
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{ACTIVE_LOW}};
    else     sync_q <= {sync_q[0], raw_i};
  end

  assign sample_c = sync_q[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_o <= level_d;
      rise_o  <= rise_d;
      fall_o  <= fall_d;
    end
  end

  // A change is accepted only after the counter has reached DB_MAX and one
  // more matching sample arrives; any mismatching sample drops it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_o;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sample_c) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sample_c) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= DB_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sample_c) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sample_c) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= DB_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/usr_input_debounce.sv
// Debouncer for 3 active-low keys and 3 switches with press/release/change
// pulses; long-press detection is built only with USR_INPUT_LONG_PRESS_EN.
module usr_input_debounce
  import usr_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                 fpga_clk_50,
  input  logic                 fpga_rst,
  usr_input_debounce_if.slave  io
);

  localparam int unsigned CNT_W = cnt_width(LONG_PRESS_CYCLES);

  logic [NUM_KEYS-1:0] key_level, key_rise, key_fall;
  logic [NUM_SWS-1:0]  sw_level, sw_rise, sw_fall;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    usr_input_db_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (1'b1)
    ) u_ch (
      .clk     (fpga_clk_50),
      .rst     (fpga_rst),
      .raw_i   (io.usr_key_i[i]),
      .level_o (key_level[i]),
      .rise_o  (key_rise[i]),
      .fall_o  (key_fall[i])
    );
  end

  for (genvar i = 0; i < NUM_SWS; i++) begin : g_sw
    usr_input_db_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (1'b0)
    ) u_ch (
      .clk     (fpga_clk_50),
      .rst     (fpga_rst),
      .raw_i   (io.usr_sw_i[i]),
      .level_o (sw_level[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i])
    );
  end

  assign io.key_level_o   = key_level;
  assign io.key_press_o   = key_rise;
  assign io.key_release_o = key_fall;
  assign io.sw_level_o    = sw_level;
  assign io.sw_change_o   = sw_rise | sw_fall;

`ifdef USR_INPUT_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0]    hold_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_q;

  // Hold counter runs while the debounced key is down and saturates, so the
  // long-press pulse fires once per press.
  always_ff @(posedge fpga_clk_50) begin
    if (fpga_rst) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (!key_level[i])             hold_q[i] <= '0;
        else if (hold_q[i] != LONG_MAX) hold_q[i] <= hold_q[i] + CNT_W'(1);
        long_q[i] <= key_level[i] && (hold_q[i] == LONG_LAST);
      end
    end
  end

  assign io.key_long_o = long_q;
`else
  assign io.key_long_o = '0;
`endif

endmodule

// File: doc/usr_input_debounce.md
USR_INPUT_DEBOUNCE -- requirements
Module: usr_input_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, the consecutive stable cycles (20 ms at 50 MHz) needed to accept a level change; legal range >= 2.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 50_000_000, the held-pressed cycles (1 s) needed for a long-press event; it SHALL exceed DEBOUNCE_CYCLES.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 fpga_clk_50  in  1  sole clock, 50 MHz.
REQ-005 fpga_rst  in  1  synchronous active-high reset.
REQ-006 usr_key_i  in  3  raw keys, active-low, asynchronous to fpga_clk_50.
REQ-007 usr_sw_i  in  3  raw switches, active-high, asynchronous.
REQ-008 key_level_o  out  3  debounced key state, 1 = pressed.
REQ-009 key_press_o  out  3  one-cycle pulse per accepted press.
REQ-010 key_release_o  out  3  one-cycle pulse per accepted release.
REQ-011 key_long_o  out  3  one-cycle pulse per long press.
REQ-012 sw_level_o  out  3  debounced switch state.
REQ-013 sw_change_o  out  3  one-cycle pulse per accepted switch change.

Function
REQ-014 Each of the 6 channels SHALL be processed independently; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-015 Each raw input SHALL pass a 2-flop synchronizer; keys SHALL be inverted after synchronization.
REQ-016 Each channel SHALL run a 4-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-017 In STABLE_x, a synchronized sample differing from x SHALL move the FSM to WAIT_y and load the stability counter with 1.
REQ-018 In WAIT_y, a sample equal to y SHALL increment the counter; a sample not equal to y SHALL return the FSM to STABLE_x with counter 0 and no output change (glitch rejected).
REQ-019 When the counter reaches DEBOUNCE_CYCLES with sample y, the FSM SHALL enter STABLE_y, the level output SHALL become y, and the matching pulse SHALL assert for exactly that one cycle, all on the same edge.
REQ-020 A clean pin transition SHALL appear on the level output exactly DEBOUNCE_CYCLES+2 edges after the first edge sampling the new pin value.
REQ-021 A pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-022 Counter width SHALL be $clog2(LONG_PRESS_CYCLES+1) bits; counters SHALL never wrap.
REQ-023 key_long_o SHALL pulse once when a key has been in STABLE_HI for LONG_PRESS_CYCLES cycles; the hold counter SHALL then saturate with no repeat until release.
REQ-024 Leaving STABLE_HI SHALL clear the hold counter; a release after a long press SHALL still give key_release_o.

Reset
REQ-025 During fpga_rst, all FSMs SHALL be in STABLE_LO, all counters 0, key synchronizer flops 1 (released), switch synchronizer flops 0, and all outputs 0.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard pending state; a key still held after reset SHALL need a full DEBOUNCE_CYCLES qualification, then give key_press_o.
REQ-027 A switch at 1 through reset SHALL give sw_change_o and sw_level_o=1 after DEBOUNCE_CYCLES+2 edges.

Configuration
REQ-028 Macro USR_INPUT_LONG_PRESS_EN defined: long-press counters and key_long_o behaviour SHALL be as in REQ-023/024.
REQ-029 Macro undefined: no hold counters SHALL be synthesized, and key_long_o SHALL remain on the port tied to 0.

Structure
REQ-030 Package usr_input_pkg SHALL hold the FSM state enum, the channel counts (3 keys, 3 switches) and the default cycle constants.
REQ-031 The per-channel synchronizer, FSM and counter SHALL be the sub-module usr_input_db_channel, instantiated 6 times; the long-press logic SHALL be in the top.

Verification (bench parameters DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
REQ-032 Key0 pin 1->0 held -> key_press_o[0] single pulse and key_level_o[0]=1 exactly 6 edges after the first edge sampling 0.
REQ-033 Key1 pin low for 3 cycles, then high -> no key_press_o, key_level_o[1] stays 0.
REQ-034 Key2 held 30 cycles, macro defined -> exactly one key_long_o[2] pulse 16 cycles after key_press_o[2]; on release, one key_release_o[2]; macro undefined -> key_long_o constantly 0.
REQ-035 sw0 and sw2 rise on the same edge -> sw_change_o[0] and [2] pulse in the same cycle; sw_level_o = 3'b101.
REQ-036 Key0 held; fpga_rst pulsed for 1 cycle at hold cycle 10 -> outputs 0 during reset; key_press_o[0] again 6 edges after reset release; key_long_o[0] only 16 cycles after that.
